m_mem_unit: RTL and testbench

- M-stage memory access unit. It consumes the EX/MEM pipeline-register outputs (pc, instr, alu_out, rt_data, Tnew) and performs the load or store over a valid/ready data-memory bus with variable latency.
- It stalls the pipeline while a bus transaction is pending, then presents extended load data to the MEM/WB register.
- Non-memory instructions pass through with zero added latency.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/dm_ext.sv | 36 +++
 rtl/m_mem_unit.sv | 162 ++++++++++++++++
 tb/tb_m_mem_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS M-stage definitions: load/store opcodes, FSM state type, access-size decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitResp,
    StDone
  } m_state_t;

  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord
  } acc_size_t;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    acc_size_t size;
    logic      sgn;
  } mem_dec_t;

  function automatic mem_dec_t decode_op(input logic [5:0] op);
    mem_dec_t d;
    d.is_load  = 1'b0;
    d.is_store = 1'b0;
    d.size     = SizeWord;
    d.sgn      = 1'b0;
    case (op)
      OP_LB:  begin d.is_load  = 1'b1; d.size = SizeByte; d.sgn = 1'b1; end
      OP_LH:  begin d.is_load  = 1'b1; d.size = SizeHalf; d.sgn = 1'b1; end
      OP_LW:  begin d.is_load  = 1'b1; d.size = SizeWord; end
      OP_LBU: begin d.is_load  = 1'b1; d.size = SizeByte; end
      OP_LHU: begin d.is_load  = 1'b1; d.size = SizeHalf; end
      OP_SB:  begin d.is_store = 1'b1; d.size = SizeByte; end
      OP_SH:  begin d.is_store = 1'b1; d.size = SizeHalf; end
      OP_SW:  begin d.is_store = 1'b1; d.size = SizeWord; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input acc_size_t size, input logic [1:0] b);
    logic m;
    case (size)
      SizeHalf: m = b[0];
      SizeWord: m = |b;
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Load extender: picks the addressed byte/half from a raw bus word and sign- or zero-extends it.
module dm_ext
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  b,
  input  acc_size_t   size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (b)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = b[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    unique case (size)
      SizeByte: data = {{24{sgn & byte_sel[7]}}, byte_sel};
      SizeHalf: data = {{16{sgn & half_sel[15]}}, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/m_mem_unit.sv
// M-stage memory access unit: drives a valid/ready data bus for loads/stores and stalls the
// pipeline until the access completes; non-memory instructions pass straight through.
module m_mem_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rt_data,
  input  logic [1:0]  in_Tnew,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_byteen,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        stall_M,
  output logic [31:0] dm_rdata,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  m_state_t        state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      b_q;
  acc_size_t       size_q;
  logic            sgn_q;

  mem_dec_t        dec;
  logic            is_mem;
  logic            misal;
  logic            start;
  logic            timeout_hit;
  logic [3:0]      byteen_new;
  logic [31:0]     wdata_new;
  logic [31:0]     ext_data;

  // PC, Tnew and the low instruction bits belong to other stages; the M unit only decodes.
  logic unused_in;
  assign unused_in = ^{in_pc, in_Tnew, in_instr[25:0]};

  assign dec    = decode_op(in_instr[31:26]);
  assign is_mem = dec.is_load | dec.is_store;
  assign misal  = is_mem & is_misaligned(dec.size, in_alu_out[1:0]);
  assign start  = (state_q == StIdle) & is_mem & ~misal;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  assign addr_err = misal;
  assign done     = (state_q == StDone);
  assign bus_err  = (state_q == StWaitResp) & ~mem_resp_valid & timeout_hit;

  // The IDLE term comes straight from the decoder, so it is gated by reset to keep the
  // pipeline unfrozen while the unit is held in reset.
  assign stall_M = reset & (start | (state_q == StReq) | (state_q == StWaitResp));

  always_comb begin
    byteen_new = 4'b1111;
    wdata_new  = in_rt_data;
    unique case (dec.size)
      SizeByte: begin
        byteen_new = 4'b0001 << in_alu_out[1:0];
        wdata_new  = {4{in_rt_data[7:0]}};
      end
      SizeHalf: begin
        byteen_new = in_alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{in_rt_data[15:0]}};
      end
      default: begin
        byteen_new = 4'b1111;
        wdata_new  = in_rt_data;
      end
    endcase
  end

  dm_ext u_dm_ext (
    .rdata (mem_resp_rdata),
    .b     (b_q),
    .size  (size_q),
    .sgn   (sgn_q),
    .data  (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      b_q            <= 2'b00;
      size_q         <= SizeWord;
      sgn_q          <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_byteen <= '0;
      mem_req_wdata  <= '0;
      dm_rdata       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mem_req_valid  <= 1'b1;
            mem_req_we     <= dec.is_store;
            mem_req_addr   <= {in_alu_out[31:2], 2'b00};
            mem_req_byteen <= byteen_new;
            mem_req_wdata  <= dec.is_store ? wdata_new : '0;
            b_q            <= in_alu_out[1:0];
            size_q         <= dec.size;
            sgn_q          <= dec.sgn;
            state_q        <= StReq;
          end else if (misal) begin
            // A misaligned access retires as a nop, so W must see a zero result.
            dm_rdata <= '0;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_byteen <= '0;
            mem_req_wdata  <= '0;
            cnt_q          <= '0;
            state_q        <= mem_req_we ? StDone : StWaitResp;
          end
        end
        StWaitResp: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_resp_valid) begin
            dm_rdata <= ext_data;
            state_q  <= StDone;
          end else if (timeout_hit) begin
            dm_rdata <= '0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A raised request must hold all of its fields until it is accepted.
  assert property (@(posedge clk) disable iff (!reset)
    (mem_req_valid && !mem_req_ready) |=>
      (mem_req_valid && $stable({mem_req_we, mem_req_addr, mem_req_byteen, mem_req_wdata})));

  assert property (@(posedge clk) disable iff (!reset) done |=> !done);

endmodule

// File: tb/tb_m_mem_unit.sv
// Bench for m_mem_unit: bus requests and load results are predicted into scoreboard queues
// when an instruction is driven and retired against the DUT at handshake / done.
module tb_m_mem_unit;
  import mips_pkg::*;

  localparam int unsigned ToCycles = 4;
  localparam logic [31:0] Nop  = 32'h0000_0000;
  localparam logic [31:0] Addu = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [31:0] in_pc, in_instr, in_alu_out, in_rt_data;
  logic [1:0]  in_Tnew;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  logic [31:0] instr_a, instr_b;
  logic        rdy_a, rdy_b, rsp_a, rsp_b;
  logic        a_valid, a_we, a_stall, a_done, a_aerr, a_berr;
  logic        b_valid, b_we, b_stall, b_done, b_aerr, b_berr;
  logic [31:0] a_addr, a_wd, a_rd, b_addr, b_wd, b_rd;
  logic [3:0]  a_be, b_be;
  logic        obs_valid, obs_we, obs_stall, obs_done, obs_aerr, obs_berr;
  logic [31:0] obs_addr, obs_wd, obs_rd;
  logic [3:0]  obs_be;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // sel steers the stimulus to the default-timeout DUT (0) or the short-timeout DUT (1).
  assign instr_a = sel ? Nop : in_instr;
  assign instr_b = sel ? in_instr : Nop;
  assign rdy_a   = ~sel & mem_req_ready;
  assign rdy_b   = sel & mem_req_ready;
  assign rsp_a   = ~sel & mem_resp_valid;
  assign rsp_b   = sel & mem_resp_valid;

  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_we    = sel ? b_we    : a_we;
  assign obs_addr  = sel ? b_addr  : a_addr;
  assign obs_be    = sel ? b_be    : a_be;
  assign obs_wd    = sel ? b_wd    : a_wd;
  assign obs_stall = sel ? b_stall : a_stall;
  assign obs_rd    = sel ? b_rd    : a_rd;
  assign obs_done  = sel ? b_done  : a_done;
  assign obs_aerr  = sel ? b_aerr  : a_aerr;
  assign obs_berr  = sel ? b_berr  : a_berr;

  m_mem_unit dut (
    .clk(clk), .reset(reset), .in_pc(in_pc), .in_instr(instr_a), .in_alu_out(in_alu_out),
    .in_rt_data(in_rt_data), .in_Tnew(in_Tnew), .mem_req_valid(a_valid), .mem_req_ready(rdy_a),
    .mem_req_we(a_we), .mem_req_addr(a_addr), .mem_req_byteen(a_be), .mem_req_wdata(a_wd),
    .mem_resp_valid(rsp_a), .mem_resp_rdata(mem_resp_rdata), .stall_M(a_stall),
    .dm_rdata(a_rd), .done(a_done), .addr_err(a_aerr), .bus_err(a_berr)
  );

  m_mem_unit #(.TIMEOUT(ToCycles)) dut_to (
    .clk(clk), .reset(reset), .in_pc(in_pc), .in_instr(instr_b), .in_alu_out(in_alu_out),
    .in_rt_data(in_rt_data), .in_Tnew(in_Tnew), .mem_req_valid(b_valid), .mem_req_ready(rdy_b),
    .mem_req_we(b_we), .mem_req_addr(b_addr), .mem_req_byteen(b_be), .mem_req_wdata(b_wd),
    .mem_resp_valid(rsp_b), .mem_resp_rdata(mem_resp_rdata), .stall_M(b_stall),
    .dm_rdata(b_rd), .done(b_done), .addr_err(b_aerr), .bus_err(b_berr)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  function automatic req_t model_req(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] rt);
    req_t r;
    r.addr = a & 32'hFFFF_FFFC;
    r.we   = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    r.be   = 4'b1111;
    r.wd   = rt;
    if (op == OP_SB) begin
      r.be = 4'b0001 << a[1:0];
      r.wd = {4{rt[7:0]}};
    end else if (op == OP_SH) begin
      r.be = a[1] ? 4'b1100 : 4'b0011;
      r.wd = {2{rt[15:0]}};
    end
    return r;
  endfunction

  // Issues one aligned memory op; rsp_dly < 0 means the bus never answers.
  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rdata, input logic [31:0] exp_rd);
    bit is_ld, in_wait, fin;
    int waits, exp_stall, vcnt, wcnt, stalls, errs;
    req_t e;
    is_ld     = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    waits     = (rsp_dly < 0) ? ToCycles : rsp_dly + 1;
    exp_stall = 2 + rdy_dly + (is_ld ? waits : 0);
    in_wait = 0; fin = 0; vcnt = 0; wcnt = 0; stalls = 0; errs = 0;
    req_q.push_back(model_req(op, addr, rt));
    if (is_ld) rd_q.push_back(exp_rd);
    in_instr = {op, 26'h0}; in_alu_out = addr; in_rt_data = rt; mem_resp_rdata = rdata;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      mem_resp_valid = in_wait && (wcnt == rsp_dly);
      #2;
      if (obs_stall) stalls++;
      if (obs_berr) begin
        errs++;
        check_eq({name, "_berr_cyc"}, wcnt, ToCycles - 1);
      end
      if (obs_done) begin
        fin = 1;
        check_eq({name, "_done_cyc"}, cyc, exp_stall);
        check_eq({name, "_stalls"}, stalls, exp_stall);
        check_eq({name, "_stall_at_done"}, {31'b0, obs_stall}, 0);
        if (is_ld) check_eq({name, "_rdata"}, obs_rd, rd_q.pop_front());
      end
      if (in_wait) wcnt++;
      mem_req_ready = 1'b0;
      if (obs_valid) begin
        if (req_q.size() == 0) begin
          check_eq({name, "_extra_req"}, {31'b0, obs_valid}, 0);
        end else begin
          e = req_q[0];
          check_eq({name, "_addr"}, obs_addr, e.addr);
          check_eq({name, "_we"}, {31'b0, obs_we}, {31'b0, e.we});
          if (!is_ld) begin
            check_eq({name, "_byteen"}, {28'b0, obs_be}, {28'b0, e.be});
            check_eq({name, "_wdata"}, obs_wd, e.wd);
          end
          if (vcnt == rdy_dly) begin
            mem_req_ready = 1'b1;
            void'(req_q.pop_front());
            in_wait = is_ld;
          end
        end
        vcnt++;
      end
      @(negedge clk);
    end
    if (!fin) check_eq({name, "_done_seen"}, {31'b0, fin}, 1);
    check_eq({name, "_berr_cnt"}, errs, (rsp_dly < 0) ? 1 : 0);
    check_eq({name, "_req_left"}, req_q.size(), 0);
    in_instr = Nop; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #2;
    check_eq({name, "_done_1cyc"}, {31'b0, obs_done}, 0);
    check_eq({name, "_stall_after"}, {31'b0, obs_stall}, 0);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq({name, "_valid"}, {31'b0, obs_valid}, 0);
    check_eq({name, "_we"}, {31'b0, obs_we}, 0);
    check_eq({name, "_addr"}, obs_addr, 0);
    check_eq({name, "_byteen"}, {28'b0, obs_be}, 0);
    check_eq({name, "_wdata"}, obs_wd, 0);
    check_eq({name, "_rdata"}, obs_rd, 0);
    check_eq({name, "_done"}, {31'b0, obs_done}, 0);
    check_eq({name, "_stall"}, {31'b0, obs_stall}, 0);
    check_eq({name, "_berr"}, {31'b0, obs_berr}, 0);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b0; in_pc = 32'h0040_0000; in_instr = Nop; in_alu_out = '0;
    in_rt_data = '0; in_Tnew = 2'd1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    #2;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    in_instr = Addu; in_alu_out = 32'h0000_1002;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq("nonmem_stall", {31'b0, obs_stall}, 0);
      check_eq("nonmem_valid", {31'b0, obs_valid}, 0);
      check_eq("nonmem_done", {31'b0, obs_done}, 0);
      check_eq("nonmem_aerr", {31'b0, obs_aerr}, 0);
      @(negedge clk);
    end
    in_instr = Nop;

    run_op("sw",  OP_SW,  32'h0000_1004, 32'hDEAD_BEEF, 0, 0, '0, '0);
    run_op("sb",  OP_SB,  32'h0000_2006, 32'h1234_5678, 3, 0, '0, '0);
    run_op("sh",  OP_SH,  32'h0000_2002, 32'hA5A5_BEEF, 1, 0, '0, '0);
    run_op("lb",  OP_LB,  32'h0000_3003, '0, 0, 5, 32'h80F0_7F01, 32'hFFFF_FF80);
    run_op("lbu", OP_LBU, 32'h0000_3003, '0, 0, 5, 32'h80F0_7F01, 32'h0000_0080);
    run_op("lh",  OP_LH,  32'h0000_3002, '0, 0, 5, 32'h80F0_7F01, 32'hFFFF_80F0);
    run_op("lhu", OP_LHU, 32'h0000_3000, '0, 0, 5, 32'h80F0_7F01, 32'h0000_7F01);

    // Reset while a load waits for its response.
    in_instr = {OP_LW, 26'h0}; in_alu_out = 32'h0000_4000; mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check_eq("rst_pre_stall", {31'b0, obs_stall}, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    in_instr = Nop;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      #2;
      check_eq("late_resp_done", {31'b0, obs_done}, 0);
      check_eq("late_resp_rdata", obs_rd, 0);
      check_eq("late_resp_stall", {31'b0, obs_stall}, 0);
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    run_op("lw_post_rst", OP_LW, 32'h0000_4000, '0, 0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D);

    in_instr = {OP_LW, 26'h0}; in_alu_out = 32'h0000_1002;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_eq("misal_aerr", {31'b0, obs_aerr}, 1);
      check_eq("misal_stall", {31'b0, obs_stall}, 0);
      check_eq("misal_valid", {31'b0, obs_valid}, 0);
      check_eq("misal_done", {31'b0, obs_done}, 0);
      @(negedge clk);
    end
    #2;
    check_eq("misal_rdata", obs_rd, 0);
    in_instr = Nop;
    @(negedge clk);

    sel = 1'b1;
    run_op("lw_pre_to", OP_LW, 32'h0000_5000, '0, 0, 1, 32'h1122_3344, 32'h1122_3344);
    run_op("lw_to",     OP_LW, 32'h0000_5004, '0, 0, -1, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
